mips_control_fsm: RTL and testbench
===================================

# mips_control_fsm

Multicycle MIPS main controller sitting directly upstream of the program counter. It sequences each instruction through fetch, decode, execute, memory and writeback states. It produces the PC enable (`PCEn`) and PC source select that drive the program counter, plus all datapath strobes. Memory accesses use a ready handshake, so the block stalls cleanly on slow instruction/data memory.

## Interface
Parameters:
- `RESET_STATE`, default `FETCH`: state loaded on reset (fixed; exposed for bench only).

Ports:
- `clk_i_top`, in, 1: single clock; all state changes on its rising edge.
- `rst_i_top`, in, 1: reset, synchronous, active-low.
- `Op`, in, 6: instr[31:26] from instruction register.
- `Funct`, in, 6: instr[5:0].
- `Zero`, in, 1: ALU zero flag.
- `MemReady`, in, 1: memory completed current access this cycle.
- `PCEn`, out, 1: program counter load enable.
- `PCSrc`, out, 2: 00 ALUResult, 01 ALUOut (branch target), 10 jump target.
- `IorD`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`, out, 1 each: datapath strobes/selects.
- `ALUSrcB`, out, 2: 00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- `ALUControl`, out, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `IllegalOp`, out, 1: one-cycle pulse on unsupported opcode.
- `State`, out, 4: current state encoding (debug).

## Operation
- States and Moore outputs. Every output not listed is 0.
  - FETCH: IRWrite, PCWrite, ALUSrcB=01, ALUOp=00.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA, ALUSrcB=10.
  - MEMREAD: IorD.
  - MEMWB: MemtoReg, RegWrite.
  - MEMWRITE: IorD, MemWrite.
  - EXECUTE: ALUSrcA, ALUOp=10.
  - ALUWB: RegDst, RegWrite.
  - BRANCH: ALUSrcA, ALUOp=01, PCSrc=01, Branch.
  - ADDIEXEC: ALUSrcA, ALUSrcB=10.
  - ADDIWB: RegWrite.
  - JUMP: PCSrc=10, PCWrite.
- Transitions:
  - FETCH→DECODE only when `MemReady`; otherwise hold.
  - DECODE dispatches on `Op`:
    - lw 100011 / sw 101011 → MEMADR.
    - R 000000 → EXECUTE.
    - beq 000100 → BRANCH.
    - addi 001000 → ADDIEXEC.
    - j 000010 → JUMP.
    - any other opcode → FETCH, with `IllegalOp`=1 for that one DECODE cycle.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB and MEMWRITE→FETCH only when `MemReady`; otherwise hold.
  - EXECUTE→ALUWB, ADDIEXEC→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Handshake gating:
  - In FETCH, IRWrite and PCWrite assert only in the cycle `MemReady`=1.
  - In MEMWRITE, MemWrite stays asserted through the wait until `MemReady`.
- `PCEn` = PCWrite | (Branch & `Zero`). Combinational, Mealy on `Zero`/`MemReady`.
- ALU decoder:
  - ALUOp 00 → 010; ALUOp 01 → 110.
  - ALUOp 10 → by `Funct`: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Unknown funct → 010.

## Timing
- Reset:
  - `rst_i_top`=0 at an edge loads FETCH.
  - While `rst_i_top`=0, PCEn, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0.
  - Reset mid-instruction abandons the instruction; no partial writeback.
- Cycles per instruction with `MemReady` tied 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `MemReady`=0 in a wait state adds exactly one cycle; no outputs change while waiting.
- `PCEn` pulses once per instruction in FETCH. It pulses a second time in JUMP, or in BRANCH when `Zero`=1.
- `Op` is sampled only in DECODE and MEMADR; changes elsewhere are ignored.

## Structure
- `mips_pkg`: `state_t` enum (4-bit, FETCH=0 … JUMP=11), opcode constants, funct constants, ALUOp and ALUControl localparams.
- Sub-module `mips_alu_decoder`: combinational ALUOp+Funct → ALUControl, instanced once.
- FSM: one `always_ff` for the state register, one `always_comb` for next-state and outputs.

## Test plan
- Reset held 3 cycles, then released with `MemReady`=1 → `State`=FETCH, `PCEn`=1 on the first post-reset cycle, 0 during reset.
- lw (Op=100011), `MemReady`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5 only.
- sw with `MemReady` low for 3 cycles in MEMWRITE → MemWrite held for 4 cycles, then FETCH.
- beq with `Zero`=1, then with `Zero`=0 → `PCEn`=1 with PCSrc=01 in BRANCH; then `PCEn`=0 in BRANCH.
- R-type Funct=101010 → ALUControl=111 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB.
- Op=111111 → `IllegalOp` pulse of 1 cycle in DECODE, return to FETCH, no RegWrite or MemWrite.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state_t (4-bit debug-visible state encoding), opcode and funct
// constants, ALUOp / ALUControl codes, mux select codes and a legal-opcode
// helper used by the decode dispatch.
package mips_pkg;

   // Encoding is visible on the State debug port, so the order is fixed.
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct field (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALUOp from the main FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUControl codes
   localparam logic [2:0] ALUCTL_ADD = 3'b010;
   localparam logic [2:0] ALUCTL_SUB = 3'b110;
   localparam logic [2:0] ALUCTL_AND = 3'b000;
   localparam logic [2:0] ALUCTL_OR  = 3'b001;
   localparam logic [2:0] ALUCTL_SLT = 3'b111;

   // PC source select
   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // True for every opcode the decode state knows how to dispatch.
   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps ALUOp plus the R-type funct field to a 3-bit ALUControl.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: alu_op (2) in, funct (6) in, alu_control (3) out.
module mips_alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALUCTL_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUCTL_ADD;
         ALUOP_SUB: alu_control = ALUCTL_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_control = ALUCTL_ADD;
               FN_SUB:  alu_control = ALUCTL_SUB;
               FN_AND:  alu_control = ALUCTL_AND;
               FN_OR:   alu_control = ALUCTL_OR;
               FN_SLT:  alu_control = ALUCTL_SLT;
               // Unsupported funct falls back to add so the datapath stays benign.
               default: alu_control = ALUCTL_ADD;
            endcase
         end
         default: alu_control = ALUCTL_ADD;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/mem/writeback
// and drives PC enable/source plus all datapath strobes. Latency: 2..5 cycles
// per instruction; each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
//
// Ports:
//   clk_i_top, rst_i_top (sync, active-low)      clock / reset
//   Op, Funct                                     instruction fields from IR
//   Zero, MemReady                                ALU zero flag, memory handshake
//   PCEn, PCSrc                                   program counter control
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg,
//   RegWrite, ALUSrcA, ALUSrcB, ALUControl        datapath strobes / selects
//   IllegalOp                                     one-cycle pulse on unknown opcode
//   State                                         current state (debug)
module mips_control_fsm
   import mips_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
) (
   input  logic       clk_i_top,
   input  logic       rst_i_top,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic [1:0] PCSrc,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic       IllegalOp,
   output logic [3:0] State
);

   state_t     state_q, state_d;

   // Ungated strobes; the write-type ones are masked by reset below.
   logic       pc_write;
   logic       branch;
   logic       ir_write_raw;
   logic       mem_write_raw;
   logic       reg_write_raw;
   logic       illegal_raw;
   logic [1:0] alu_op;

   always_ff @(posedge clk_i_top) begin
      if (!rst_i_top) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      alu_op        = ALUOP_ADD;
      PCSrc         = PCSRC_ALURESULT;
      IorD          = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_REGB;

      case (state_q)
         FETCH: begin
            ALUSrcB = SRCB_FOUR;
            alu_op  = ALUOP_ADD;
            // IR load and PC+4 commit only in the cycle memory delivers the word.
            if (MemReady) begin
               ir_write_raw = 1'b1;
               pc_write     = 1'b1;
               state_d      = DECODE;
            end
         end

         DECODE: begin
            // Precompute the branch target while the opcode is dispatched.
            ALUSrcB = SRCB_IMM_SH2;
            alu_op  = ALUOP_ADD;
            case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
            illegal_raw = !is_legal_op(Op);
         end

         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            // Only lw/sw reach here; anything not lw is treated as a store.
            state_d = (Op == OP_LW) ? MEMREAD : MEMWRITE;
         end

         MEMREAD: begin
            IorD = 1'b1;
            if (MemReady) begin
               state_d = MEMWB;
            end
         end

         MEMWB: begin
            MemtoReg      = 1'b1;
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end

         MEMWRITE: begin
            // Write strobe is held for the whole wait, not just the final cycle.
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
            if (MemReady) begin
               state_d = FETCH;
            end
         end

         EXECUTE: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
            state_d = ALUWB;
         end

         ALUWB: begin
            RegDst        = 1'b1;
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end

         BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            PCSrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
            state_d = FETCH;
         end

         ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = ADDIWB;
         end

         ADDIWB: begin
            reg_write_raw = 1'b1;
            state_d       = FETCH;
         end

         JUMP: begin
            PCSrc    = PCSRC_JUMP;
            pc_write = 1'b1;
            state_d  = FETCH;
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   mips_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (Funct),
      .alu_control (ALUControl)
   );

   // Architectural side effects are suppressed while reset is held so that an
   // instruction interrupted by reset can never commit a partial result.
   assign PCEn      = rst_i_top & (pc_write | (branch & Zero));
   assign IRWrite   = rst_i_top & ir_write_raw;
   assign MemWrite  = rst_i_top & mem_write_raw;
   assign RegWrite  = rst_i_top & reg_write_raw;
   assign IllegalOp = rst_i_top & illegal_raw;
   assign State     = state_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: directed literal rows followed by randomized
// stimulus, all checked every cycle against an instruction-level model that
// keeps the remaining steps of the current instruction in a queue.
module tb_mips_control_fsm;

   // State numbering as exposed on the State debug port.
   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                  S_MEMWB = 4, S_MEMWRITE = 5, S_EXECUTE = 6, S_ALUWB = 7,
                  S_BRANCH = 8, S_ADDIEXEC = 9, S_ADDIWB = 10, S_JUMP = 11;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, mr;

   logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
   logic       ALUSrcA, IllegalOp;
   logic [1:0] PCSrc, ALUSrcB;
   logic [2:0] ALUControl;
   logic [3:0] State;

   mips_control_fsm dut (
      .clk_i_top (clk),
      .rst_i_top (rst_n),
      .Op        (op),
      .Funct     (funct),
      .Zero      (zero),
      .MemReady  (mr),
      .PCEn      (PCEn),
      .PCSrc     (PCSrc),
      .IorD      (IorD),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUControl(ALUControl),
      .IllegalOp (IllegalOp),
      .State     (State)
   );

   logic [15:0] dut_vec;
   assign dut_vec = {PCEn, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                     RegWrite, ALUSrcA, ALUSrcB, ALUControl, IllegalOp};

   int n_cmp = 0;
   int n_bad = 0;

   // Model: current step plus queue of steps still to come for this instruction.
   int mstate;
   int route[$];
   logic [5:0] instr_op;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [5:0] o);
      return o == 6'h23 || o == 6'h2b || o == 6'h00 || o == 6'h04 ||
             o == 6'h08 || o == 6'h02;
   endfunction

   function automatic logic [15:0] model_out(input int st, input logic r,
         input logic [5:0] o, input logic [5:0] f, input logic z, input logic m);
      logic pcw, br, pcen, iord, mw, irw, rd, m2r, rw, asa, ill;
      logic [1:0] pcsrc, asb;
      logic [2:0] actl;
      pcw   = (st == S_FETCH && m) || st == S_JUMP;
      br    = (st == S_BRANCH);
      pcen  = pcw | (br & z);
      pcsrc = br ? 2'd1 : (st == S_JUMP) ? 2'd2 : 2'd0;
      iord  = (st == S_MEMREAD) || (st == S_MEMWRITE);
      mw    = (st == S_MEMWRITE);
      irw   = (st == S_FETCH && m);
      rd    = (st == S_ALUWB);
      m2r   = (st == S_MEMWB);
      rw    = (st == S_MEMWB) || (st == S_ALUWB) || (st == S_ADDIWB);
      asa   = (st == S_MEMADR) || (st == S_EXECUTE) || br || (st == S_ADDIEXEC);
      asb   = (st == S_FETCH) ? 2'd1 : (st == S_DECODE) ? 2'd3 :
              (st == S_MEMADR || st == S_ADDIEXEC) ? 2'd2 : 2'd0;
      actl  = 3'd2;
      if (br) actl = 3'd6;
      if (st == S_EXECUTE) begin
         case (f)
            6'h22:   actl = 3'd6;
            6'h24:   actl = 3'd0;
            6'h25:   actl = 3'd1;
            6'h2a:   actl = 3'd7;
            default: actl = 3'd2;
         endcase
      end
      ill = (st == S_DECODE) && !legal(o);
      if (!r) begin
         pcen = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ill = 1'b0;
      end
      return {pcen, pcsrc, iord, mw, irw, rd, m2r, rw, asa, asb, actl, ill};
   endfunction

   task automatic model_advance();
      if (!rst_n) begin
         mstate = S_FETCH;
         route.delete();
      end else if (mstate == S_FETCH) begin
         if (mr) mstate = S_DECODE;
      end else if (mstate == S_DECODE) begin
         case (op)
            6'h23:   route = '{S_MEMADR, S_MEMREAD, S_MEMWB};
            6'h2b:   route = '{S_MEMADR, S_MEMWRITE};
            6'h00:   route = '{S_EXECUTE, S_ALUWB};
            6'h04:   route = '{S_BRANCH};
            6'h08:   route = '{S_ADDIEXEC, S_ADDIWB};
            6'h02:   route = '{S_JUMP};
            default: route.delete();
         endcase
         mstate = (route.size() > 0) ? route.pop_front() : S_FETCH;
      end else if ((mstate == S_MEMREAD || mstate == S_MEMWRITE) && !mr) begin
         mstate = mstate;
      end else begin
         mstate = (route.size() > 0) ? route.pop_front() : S_FETCH;
      end
   endtask

   // One clock: compare at the falling edge, advance model, resume after rise.
   task automatic cycle();
      @(negedge clk);
      chk("state", int'(State), mstate);
      chk("outputs", int'(dut_vec), int'(model_out(mstate, rst_n, op, funct, zero, mr)));
      model_advance();
      @(posedge clk);
      #1;
   endtask

   // Directed row: drive inputs, check hand-computed literals, then run a cycle.
   task automatic drow(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic m, input int st,
                       input logic pcen_e, input logic [1:0] pcsrc_e,
                       input logic rw_e, input logic mw_e, input logic ill_e,
                       input logic [2:0] alu_e);
      rst_n = r; op = o; funct = f; zero = z; mr = m;
      #2;
      chk("lit_state", int'(State), st);
      chk("lit_model_state", mstate, st);
      chk("lit_pcen", int'(PCEn), int'(pcen_e));
      chk("lit_pcsrc", int'(PCSrc), int'(pcsrc_e));
      chk("lit_regwrite", int'(RegWrite), int'(rw_e));
      chk("lit_memwrite", int'(MemWrite), int'(mw_e));
      chk("lit_illegal", int'(IllegalOp), int'(ill_e));
      chk("lit_aluctl", int'(ALUControl), int'(alu_e));
      cycle();
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 6))
         0: return 6'h23;
         1: return 6'h2b;
         2: return 6'h00;
         3: return 6'h04;
         4: return 6'h08;
         5: return 6'h02;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] pick_funct();
      case ($urandom_range(0, 5))
         0: return 6'h20;
         1: return 6'h22;
         2: return 6'h24;
         3: return 6'h25;
         4: return 6'h2a;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0; mr = 1'b1;
      mstate = S_FETCH;
      instr_op = 6'h00;
      @(posedge clk);
      #1;

      // Reset held three cycles: FETCH, PCEn forced low.
      for (int i = 0; i < 3; i++)
         drow(0, 6'h23, 6'h00, 0, 1, S_FETCH,    0, 2'd0, 0, 0, 0, 3'd2);
      // lw, MemReady high: 5 cycles, writeback only in the last.
      drow(1, 6'h23, 6'h00, 0, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h23, 6'h00, 0, 1, S_DECODE,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h23, 6'h00, 0, 1, S_MEMADR,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h23, 6'h00, 0, 1, S_MEMREAD,  0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h23, 6'h00, 0, 1, S_MEMWB,    0, 2'd0, 1, 0, 0, 3'd2);
      // sw with three wait cycles: MemWrite held four cycles.
      drow(1, 6'h2b, 6'h00, 0, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h2b, 6'h00, 0, 1, S_DECODE,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h2b, 6'h00, 0, 1, S_MEMADR,   0, 2'd0, 0, 0, 0, 3'd2);
      for (int i = 0; i < 3; i++)
         drow(1, 6'h2b, 6'h00, 0, 0, S_MEMWRITE, 0, 2'd0, 0, 1, 0, 3'd2);
      drow(1, 6'h2b, 6'h00, 0, 1, S_MEMWRITE, 0, 2'd0, 0, 1, 0, 3'd2);
      // beq taken then not taken.
      drow(1, 6'h04, 6'h00, 1, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h04, 6'h00, 1, 1, S_DECODE,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h04, 6'h00, 1, 1, S_BRANCH,   1, 2'd1, 0, 0, 0, 3'd6);
      drow(1, 6'h04, 6'h00, 0, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h04, 6'h00, 0, 1, S_DECODE,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h04, 6'h00, 0, 1, S_BRANCH,   0, 2'd1, 0, 0, 0, 3'd6);
      // R-type slt.
      drow(1, 6'h00, 6'h2a, 0, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h00, 6'h2a, 0, 1, S_DECODE,   0, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h00, 6'h2a, 0, 1, S_EXECUTE,  0, 2'd0, 0, 0, 0, 3'd7);
      drow(1, 6'h00, 6'h2a, 0, 1, S_ALUWB,    0, 2'd0, 1, 0, 0, 3'd2);
      // Illegal opcode: one-cycle pulse in DECODE, then back to FETCH.
      drow(1, 6'h3f, 6'h00, 0, 1, S_FETCH,    1, 2'd0, 0, 0, 0, 3'd2);
      drow(1, 6'h3f, 6'h00, 0, 1, S_DECODE,   0, 2'd0, 0, 0, 1, 3'd2);
      drow(1, 6'h3f, 6'h00, 0, 0, S_FETCH,    0, 2'd0, 0, 0, 0, 3'd2);

      // Randomized: occasional mid-instruction reset, slow memory, and Op
      // scrambled in every state where it must be ignored.
      for (int i = 0; i < 4000; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         mr    = ($urandom_range(0, 3) != 0);
         zero  = 1'($urandom_range(0, 1));
         funct = pick_funct();
         if (mstate == S_FETCH) instr_op = pick_op();
         op = (mstate == S_DECODE || mstate == S_MEMADR) ? instr_op : 6'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
